// File: rtl/reg_file_wb_if.sv
// Exec <-> register file/writeback bus: operand selects, exec result, operand
// readback, writeback status and the debug read port.
interface reg_file_wb_if #(
    parameter int DW = 16,
    parameter int AW = 3,
    parameter int CW = 8
);
    logic [3:0]    op_code;
    logic [AW-1:0] dst_sel;
    logic [AW-1:0] src_sel;
    logic [DW-1:0] reg_in;
    logic [DW-1:0] reg_a;
    logic [DW-1:0] reg_b;
    logic          wb_pending;
    logic [AW-1:0] wb_addr;
    logic [CW-1:0] commit_cnt;
    logic [AW-1:0] dbg_sel;
    logic [DW-1:0] dbg_data;

    modport master (
        output op_code, dst_sel, src_sel, reg_in, dbg_sel,
        input  reg_a, reg_b, wb_pending, wb_addr, commit_cnt, dbg_data
    );

    modport slave (
        input  op_code, dst_sel, src_sel, reg_in, dbg_sel,
        output reg_a, reg_b, wb_pending, wb_addr, commit_cnt, dbg_data
    );
endinterface

// File: rtl/reg_file_wb.sv
// Register file and writeback stage for the 16-bit teaching CPU: commits the exec
// result one edge after capture and forwards the pending result to both operands.
module reg_file_wb #(
    parameter int DW = 16,
    parameter int AW = 3,
    parameter int CW = 8
) (
    input  logic        clk_ex,
    input  logic        reset,
    reg_file_wb_if.slave bus
);
    localparam int NREG = 2 ** AW;
    localparam logic [3:0] LAST_VALID_OP = 4'd4;

    logic [DW-1:0] regs_reg [NREG];
    logic          wb_pending_reg;
    logic [AW-1:0] wb_addr_reg;
    logic [CW-1:0] commit_cnt_reg;
    logic [NREG-1:0] wr_en;
    logic          valid_op;
    logic          bypass_a;
    logic          bypass_b;

    // One-hot commit enable; only the register named by the pending entry is written.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_wr_en
            assign wr_en[gi] = wb_pending_reg && (wb_addr_reg == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk_ex or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_en[i]) begin
                    regs_reg[i] <= bus.reg_in;
                end
            end
        end
    end

    assign valid_op = (bus.op_code <= LAST_VALID_OP);

    // Commit uses the old pending entry while the new one is captured on the same edge.
    always_ff @(posedge clk_ex or negedge reset) begin
        if (!reset) begin
            wb_pending_reg <= 1'b0;
            wb_addr_reg    <= '0;
            commit_cnt_reg <= '0;
        end else begin
            if (wb_pending_reg) begin
                commit_cnt_reg <= commit_cnt_reg + 1'b1;
            end
            wb_pending_reg <= valid_op;
            wb_addr_reg    <= bus.dst_sel;
        end
    end

    assign bypass_a = wb_pending_reg && (bus.dst_sel == wb_addr_reg);
    assign bypass_b = wb_pending_reg && (bus.src_sel == wb_addr_reg);

    assign bus.reg_a      = bypass_a ? bus.reg_in : regs_reg[bus.dst_sel];
    assign bus.reg_b      = bypass_b ? bus.reg_in : regs_reg[bus.src_sel];
    assign bus.dbg_data   = regs_reg[bus.dbg_sel];
    assign bus.wb_pending = wb_pending_reg;
    assign bus.wb_addr    = wb_addr_reg;
    assign bus.commit_cnt = commit_cnt_reg;
endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: vector table for dependent sequences plus
// hand sequences for reset-in-flight and commit counter wrap.
module tb_reg_file_wb;
    logic clk_ex = 1'b0;
    logic reset  = 1'b0;
    int   tests  = 0;
    int   failed = 0;

    reg_file_wb_if bus ();

    reg_file_wb dut (
        .clk_ex (clk_ex),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_ex = ~clk_ex;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  dst;
        logic [2:0]  src;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic [15:0] res;
        logic        exp_pend;
        logic [7:0]  exp_cnt;
        logic [2:0]  dbg;
        logic [15:0] exp_dbg;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    logic [15:0] mreg [8];
    logic        mpend;
    logic [2:0]  mpaddr;
    logic [15:0] cur_rin;
    logic [15:0] exp_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // op, dst, src, exp_a, exp_b, res, exp_pend, exp_cnt, dbg, exp_dbg
        vecs[0]  = '{4'd3,  3'd1, 3'd0, 16'h0000, 16'h0000, 16'h0034, 1'b1, 8'd0, 3'd1, 16'h0000};
        vecs[1]  = '{4'd4,  3'd1, 3'd0, 16'h0034, 16'h0000, 16'h1234, 1'b1, 8'd1, 3'd1, 16'h0034};
        vecs[2]  = '{4'd7,  3'd1, 3'd1, 16'h1234, 16'h1234, 16'h1234, 1'b0, 8'd2, 3'd1, 16'h1234};
        vecs[3]  = '{4'd0,  3'd2, 3'd0, 16'h0000, 16'h0000, 16'd5,    1'b1, 8'd2, 3'd2, 16'h0000};
        vecs[4]  = '{4'd0,  3'd3, 3'd0, 16'h0000, 16'h0000, 16'd7,    1'b1, 8'd3, 3'd2, 16'd5};
        vecs[5]  = '{4'd1,  3'd2, 3'd3, 16'd5,    16'd7,    16'd12,   1'b1, 8'd4, 3'd3, 16'd7};
        vecs[6]  = '{4'd1,  3'd2, 3'd3, 16'd12,   16'd7,    16'd19,   1'b1, 8'd5, 3'd2, 16'd12};
        vecs[7]  = '{4'd0,  3'd4, 3'd0, 16'h0000, 16'h0000, 16'h8000, 1'b1, 8'd6, 3'd2, 16'd19};
        vecs[8]  = '{4'd2,  3'd4, 3'd4, 16'h8000, 16'h8000, 16'h0000, 1'b1, 8'd7, 3'd4, 16'h8000};
        vecs[9]  = '{4'd9,  3'd4, 3'd4, 16'h0000, 16'h0000, 16'h0000, 1'b0, 8'd8, 3'd4, 16'h0000};
        vecs[10] = '{4'd15, 3'd4, 3'd4, 16'h0000, 16'h0000, 16'hBEEF, 1'b0, 8'd8, 3'd4, 16'h0000};
        vecs[11] = '{4'd15, 3'd4, 3'd2, 16'h0000, 16'd19,   16'hBEEF, 1'b0, 8'd8, 3'd1, 16'h1234};

        bus.op_code = 4'd15;
        bus.dst_sel = '0;
        bus.src_sel = '0;
        bus.reg_in  = '0;
        bus.dbg_sel = '0;

        // Reset state
        repeat (2) @(posedge clk_ex);
        @(negedge clk_ex);
        reset = 1'b1;
        for (int r = 0; r < 8; r++) begin
            bus.dbg_sel = 3'(r);
            #1;
            check("reset_dbg", {16'h0, bus.dbg_data}, 32'h0);
        end
        check("reset_pend", {31'h0, bus.wb_pending}, 32'h0);
        check("reset_cnt", {24'h0, bus.commit_cnt}, 32'h0);
        $display("[TB] reset: all registers read back, pending=%0b cnt=%0d", bus.wb_pending, bus.commit_cnt);

        // Dependent-instruction vectors
        for (int v = 0; v < NVEC; v++) begin
            @(negedge clk_ex);
            bus.op_code = vecs[v].op;
            bus.dst_sel = vecs[v].dst;
            bus.src_sel = vecs[v].src;
            bus.dbg_sel = vecs[v].dbg;
            #1;
            check("vec_reg_a", {16'h0, bus.reg_a}, {16'h0, vecs[v].exp_a});
            check("vec_reg_b", {16'h0, bus.reg_b}, {16'h0, vecs[v].exp_b});
            @(posedge clk_ex);
            #1;
            bus.reg_in = vecs[v].res;
            check("vec_pend", {31'h0, bus.wb_pending}, {31'h0, vecs[v].exp_pend});
            check("vec_cnt", {24'h0, bus.commit_cnt}, {24'h0, vecs[v].exp_cnt});
            check("vec_dbg", {16'h0, bus.dbg_data}, {16'h0, vecs[v].exp_dbg});
            $display("[TB] vec %0d op=%0d dst=%0d src=%0d a=%h b=%h cnt=%0d", v, vecs[v].op,
                     vecs[v].dst, vecs[v].src, vecs[v].exp_a, vecs[v].exp_b, bus.commit_cnt);
        end

        // Reset asserted while a MOV into R5 is pending
        @(negedge clk_ex);
        bus.op_code = 4'd0;
        bus.dst_sel = 3'd5;
        bus.src_sel = 3'd0;
        @(posedge clk_ex);
        #1;
        bus.reg_in = 16'hAAAA;
        check("inflight_pend", {31'h0, bus.wb_pending}, 32'h1);
        check("inflight_addr", {29'h0, bus.wb_addr}, 32'h5);
        #2;
        reset = 1'b0;
        bus.dbg_sel = 3'd1;
        #1;
        check("async_pend", {31'h0, bus.wb_pending}, 32'h0);
        check("async_addr", {29'h0, bus.wb_addr}, 32'h0);
        check("async_cnt", {24'h0, bus.commit_cnt}, 32'h0);
        check("async_r1", {16'h0, bus.dbg_data}, 32'h0);
        @(negedge clk_ex);
        bus.op_code = 4'd15;
        @(posedge clk_ex);
        @(negedge clk_ex);
        reset = 1'b1;
        bus.dbg_sel = 3'd5;
        #1;
        check("after_rst_r5", {16'h0, bus.dbg_data}, 32'h0);
        check("after_rst_reg_a", {16'h0, bus.reg_a}, 32'h0);
        $display("[TB] reset mid-op: pending=%0b R5=%h", bus.wb_pending, bus.dbg_data);

        // 256 back-to-back MOVs with paired destinations to exercise dst==src bypass
        for (int r = 0; r < 8; r++) mreg[r] = '0;
        mpend   = 1'b0;
        mpaddr  = '0;
        cur_rin = bus.reg_in;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk_ex);
            bus.op_code = 4'd0;
            bus.dst_sel = 3'((i / 2) % 8);
            bus.src_sel = 3'((i / 2) % 8);
            #1;
            exp_rd = (mpend && bus.dst_sel == mpaddr) ? cur_rin : mreg[bus.dst_sel];
            check("wrap_reg_a", {16'h0, bus.reg_a}, {16'h0, exp_rd});
            check("wrap_reg_b", {16'h0, bus.reg_b}, {16'h0, exp_rd});
            @(posedge clk_ex);
            #1;
            if (mpend) mreg[mpaddr] = cur_rin;
            mpend   = 1'b1;
            mpaddr  = bus.dst_sel;
            cur_rin = 16'(i * 37 + 5);
            bus.reg_in = cur_rin;
            check("wrap_cnt", {24'h0, bus.commit_cnt}, i & 32'hFF);
            $display("[TB] mov %0d dst=%0d read=%h cnt=%0d", i, bus.dst_sel, exp_rd, bus.commit_cnt);
        end
        check("wrap_cnt_max", {24'h0, bus.commit_cnt}, 32'd255);
        @(negedge clk_ex);
        bus.op_code = 4'd15;
        @(posedge clk_ex);
        #1;
        mreg[mpaddr] = cur_rin;
        check("wrap_cnt_zero", {24'h0, bus.commit_cnt}, 32'h0);
        check("wrap_pend", {31'h0, bus.wb_pending}, 32'h0);
        for (int r = 0; r < 8; r++) begin
            bus.dbg_sel = 3'(r);
            #1;
            check("wrap_dbg", {16'h0, bus.dbg_data}, {16'h0, mreg[r]});
        end
        $display("[TB] wrap: cnt=%0d", bus.commit_cnt);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
